// File: rtl/cpu_pkg.sv
// cpu_pkg: control-state encodings and ALU flag layout shared by the control
// sequencer and the combinational next-state logic.
//   state constants : S_IDLE, S_DECODE, S_FETCH and the flag-producing states
//   flag indices    : FLAG_N/P/Z/C bit positions inside the 4-bit flag word
//   helpers         : is_flag_state() and hold-cause decode
package cpu_pkg;

   typedef logic [7:0] state_t;

   localparam state_t S_IDLE   = 8'h00;
   localparam state_t S_DECODE = 8'h01;
   localparam state_t S_FETCH  = 8'h0F;
   localparam state_t S_SUB2   = 8'h08;
   localparam state_t S_ADD2   = 8'h0B;
   localparam state_t S_XOR2   = 8'h0E;
   localparam state_t S_CPU1   = 8'h27;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_P = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 0;

   typedef struct packed {
      logic n;
      logic p;
      logic z;
      logic c;
   } flags_t;

   // Why the sequencer is not committing next_state this cycle.
   typedef enum logic [1:0] {
      HoldNone,
      HoldHalt,
      HoldFetch
   } hold_e;

   // States whose exit edge captures the ALU flags.
   function automatic logic is_flag_state(input state_t s);
      return (s == S_ADD2) || (s == S_SUB2) || (s == S_XOR2) || (s == S_CPU1);
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the control sequencer and the
// datapath / next-state logic.
//   master : the sequencer (drives state, instr, status_reg, halted,
//            retired, mem_timeout; receives run, next_state, memory and ALU
//            inputs)
//   slave  : the datapath / next-state side, mirror of master
interface control_sequencer_if;
   import cpu_pkg::*;

   logic        run;
   state_t      next_state;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [3:0]  alu_flags;

   state_t      state;
   logic [15:0] instr;
   logic [3:0]  status_reg;
   logic        halted;
   logic [15:0] retired;
   logic        mem_timeout;

   modport master (
      input  run, next_state, mem_rdata, mem_ready, alu_flags,
      output state, instr, status_reg, halted, retired, mem_timeout
   );

   modport slave (
      output run, next_state, mem_rdata, mem_ready, alu_flags,
      input  state, instr, status_reg, halted, retired, mem_timeout
   );

endinterface

// File: rtl/control_sequencer_wait_timer.sv
// wait_timer: saturating 16-bit fetch-wait counter.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : force the count to zero (has priority over inc)
//   inc        : add one this cycle, saturating at 16'hFFFF
//   reached    : the count being written this edge is >= WAIT_MAX, so a
//                sticky flag registered from it rises on the same edge the
//                count gets there
module wait_timer #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic reached
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 16'h0000;
      end else if (inc && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'h0001;
      end
   end

   assign reached = ({16'h0000, count_d} >= WAIT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= 16'h0000;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: sequential half of the CPU control unit.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : control_sequencer_if.master
//                in : run, next_state, mem_rdata, mem_ready, alu_flags
//                out: state, instr, status_reg, halted, retired, mem_timeout
// Commits next_state each cycle unless parked in idle (run low) or waiting
// on memory in fetch; latches the instruction word and ALU flags, counts
// retired instructions and flags an over-long fetch wait.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   control_sequencer_if.master        bus
);

   state_t      state_q;
   logic [15:0] instr_q;
   flags_t      status_q;
   logic        halted_q;
   logic [15:0] retired_q;
   logic        mem_timeout_q;

   hold_e       hold;
   logic        advance;
   logic        fetch_wait;
   logic        fetch_take;
   logic        halt_cond;
   logic        retire;
   logic        wait_reached;

   always_comb begin
      hold = HoldNone;
      if ((state_q == S_IDLE) && !bus.run) begin
         hold = HoldHalt;
      end else if ((state_q == S_FETCH) && !bus.mem_ready) begin
         hold = HoldFetch;
      end
   end

   assign advance    = (hold == HoldNone);
   assign halt_cond  = (hold == HoldHalt);
   assign fetch_wait = (hold == HoldFetch);
   assign fetch_take = (state_q == S_FETCH) && bus.mem_ready;
   // An instruction retires on the edge that returns control to idle.
   assign retire     = advance && (state_q != S_IDLE) && (bus.next_state == S_IDLE);

   wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!fetch_wait),
      .inc     (fetch_wait),
      .reached (wait_reached)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         instr_q       <= 16'h0000;
         status_q      <= '0;
         halted_q      <= 1'b1;
         retired_q     <= 16'h0000;
         mem_timeout_q <= 1'b0;
      end else begin
         if (advance) begin
            // No legality check: unknown encodings fall back to idle through
            // the next-state logic's default arm.
            state_q <= bus.next_state;
         end
         if (fetch_take) begin
            instr_q <= bus.mem_rdata;
         end
         if (is_flag_state(state_q)) begin
            status_q <= flags_t'(bus.alu_flags);
         end
         if (retire) begin
            retired_q <= retired_q + 16'h0001;
         end
         halted_q      <= halt_cond;
         // Sticky; the fetch itself keeps waiting for mem_ready.
         mem_timeout_q <= mem_timeout_q | wait_reached;
      end
   end

   assign bus.state       = state_q;
   assign bus.instr       = instr_q;
   assign bus.status_reg  = status_q;
   assign bus.halted      = halted_q;
   assign bus.retired     = retired_q;
   assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer with a small
// table model of the next-state logic (00,0F,01,09,0A,0B,00 path).
module tb_control_sequencer;
   import cpu_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   control_sequencer_if bus ();

   control_sequencer #(
      .WAIT_MAX (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Next-state logic model for a single ADD-style instruction.
   always_comb begin
      unique case (bus.state)
         8'h00:   bus.next_state = 8'h0F;
         8'h0F:   bus.next_state = 8'h01;
         8'h01:   bus.next_state = 8'h09;
         8'h09:   bus.next_state = 8'h0A;
         8'h0A:   bus.next_state = 8'h0B;
         8'h0B:   bus.next_state = 8'h00;
         default: bus.next_state = 8'h00;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},   32'(bus.state),       32'h00);
      check({tag, "_instr"},   32'(bus.instr),       32'h0000);
      check({tag, "_status"},  32'(bus.status_reg),  32'h0);
      check({tag, "_halted"},  32'(bus.halted),      32'h1);
      check({tag, "_retired"}, 32'(bus.retired),     32'h0000);
      check({tag, "_tmo"},     32'(bus.mem_timeout), 32'h0);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h2123;
      bus.alu_flags = 4'b0010;
      step();
      step();
      check_reset_vals("rst");

      // Basic instruction: 00,0F,01,09,0A,0B,00
      reset = 1'b0;
      step();
      check("t1_fetch", 32'(bus.state), 32'h0F);
      check("t1_halted_low", 32'(bus.halted), 32'h0);
      step();
      check("t1_decode", 32'(bus.state), 32'h01);
      check("t1_instr", 32'(bus.instr), 32'h2123);
      check("t1_status_early", 32'(bus.status_reg), 32'h0);
      step();
      step();
      step();
      check("t1_add2", 32'(bus.state), 32'h0B);
      check("t1_status_pre", 32'(bus.status_reg), 32'h0);
      step();
      check("t1_idle", 32'(bus.state), 32'h00);
      check("t1_status", 32'(bus.status_reg), 32'h2);
      check("t1_retired", 32'(bus.retired), 32'h0001);

      // Fetch with 3 wait cycles
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'hFFFF;
      step();
      check("t2_fetch", 32'(bus.state), 32'h0F);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_hold", 32'(bus.state), 32'h0F);
         check("t2_instr_stable", 32'(bus.instr), 32'h2123);
         check("t2_tmo", 32'(bus.mem_timeout), 32'h0);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'hD005;
      step();
      check("t2_decode", 32'(bus.state), 32'h01);
      check("t2_instr", 32'(bus.instr), 32'hD005);
      check("t2_tmo_end", 32'(bus.mem_timeout), 32'h0);
      for (int i = 0; i < 4; i++) step();
      check("t2_idle", 32'(bus.state), 32'h00);
      check("t2_retired", 32'(bus.retired), 32'h0002);

      // 10 wait cycles with WAIT_MAX=4
      bus.mem_ready = 1'b0;
      step();
      for (int i = 1; i <= 10; i++) begin
         step();
         check("t3_hold", 32'(bus.state), 32'h0F);
         check($sformatf("t3_tmo_%0d", i), 32'(bus.mem_timeout), (i < 4) ? 32'h0 : 32'h1);
      end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 16'h1234;
      step();
      check("t3_decode", 32'(bus.state), 32'h01);
      check("t3_instr", 32'(bus.instr), 32'h1234);
      check("t3_tmo_sticky", 32'(bus.mem_timeout), 32'h1);
      for (int i = 0; i < 4; i++) step();
      check("t3_retired", 32'(bus.retired), 32'h0003);

      // run dropped mid-ADD
      for (int i = 0; i < 4; i++) step();
      check("t4_add1", 32'(bus.state), 32'h0A);
      bus.run       = 1'b0;
      bus.alu_flags = 4'b1001;
      step();
      check("t4_add2", 32'(bus.state), 32'h0B);
      step();
      check("t4_idle", 32'(bus.state), 32'h00);
      check("t4_retired", 32'(bus.retired), 32'h0004);
      check("t4_status", 32'(bus.status_reg), 32'h9);
      check("t4_halted_lag", 32'(bus.halted), 32'h0);
      step();
      check("t4_park", 32'(bus.state), 32'h00);
      check("t4_halted", 32'(bus.halted), 32'h1);
      step();
      check("t4_park2", 32'(bus.state), 32'h00);
      check("t4_retired_hold", 32'(bus.retired), 32'h0004);
      bus.run       = 1'b1;
      bus.mem_rdata = 16'h5A5A;
      step();
      check("t4_resume", 32'(bus.state), 32'h0F);
      check("t4_unhalt", 32'(bus.halted), 32'h0);
      for (int i = 0; i < 5; i++) step();
      check("t4_retired2", 32'(bus.retired), 32'h0005);
      check("t4_instr", 32'(bus.instr), 32'h5A5A);

      // Retire counter wrap
      bus.run = 1'b0;
      step();
      force dut.retired_q = 16'hFFFF;
      step();
      release dut.retired_q;
      bus.run = 1'b1;
      for (int i = 0; i < 6; i++) step();
      check("t5_idle", 32'(bus.state), 32'h00);
      check("t5_wrap", 32'(bus.retired), 32'h0000);

      // Reset during S_ADD1
      for (int i = 0; i < 4; i++) step();
      check("t6_add1", 32'(bus.state), 32'h0A);
      reset = 1'b1;
      step();
      check_reset_vals("t6");

      // Reset during a ready fetch must not latch the word
      reset = 1'b0;
      step();
      check("t7_fetch", 32'(bus.state), 32'h0F);
      reset         = 1'b1;
      bus.mem_rdata = 16'hBEEF;
      step();
      check("t7_state", 32'(bus.state), 32'h00);
      check("t7_instr", 32'(bus.instr), 32'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
